// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Write-back arbiter and pending-write scoreboard for the 32x32 register
//   file. Two producers share the single write port: A (single-cycle ALU /
//   load path) and B (long-latency unit). Grants are round-robin; the winning
//   write is registered onto the RegWrite / Write_reg / Write_data port.
//   o_busy flags registers that an issued B operation has not yet written.
//
// Ports
//   i_clk, i_rst_n              clock, async active-low reset
//   i_a_valid/reg/data          requester A write request
//   o_a_ready                   A granted this cycle
//   i_b_valid/reg/data          requester B write request
//   o_b_ready                   B granted this cycle
//   i_issue_valid/reg           B-type operation issued, destination index
//   o_RegWrite/Write_reg/Write_data  registered register-file write port
//   o_busy                      per-register pending-B-write mask
module rf_wb_arbiter (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_a_valid,
    input  logic [4:0]  i_a_reg,
    input  logic [31:0] i_a_data,
    output logic        o_a_ready,
    input  logic        i_b_valid,
    input  logic [4:0]  i_b_reg,
    input  logic [31:0] i_b_data,
    output logic        o_b_ready,
    input  logic        i_issue_valid,
    input  logic [4:0]  i_issue_reg,
    output logic        o_RegWrite,
    output logic [4:0]  o_Write_reg,
    output logic [31:0] o_Write_data,
    output logic [31:0] o_busy
);

    // 1: B was granted most recently, so A wins the next tie.
    logic        last_b;
    logic        src_b;
    logic        grant_a;
    logic        grant_b;
    logic        xfer;
    logic [4:0]  sel_reg;
    logic [31:0] sel_data;
    logic [31:0] busy_set;
    logic [31:0] busy_clr;

    always_comb begin
        grant_a  = i_a_valid & (~i_b_valid | last_b);
        grant_b  = i_b_valid & (~i_a_valid | ~last_b);
        xfer     = grant_a | grant_b;
        sel_reg  = grant_a ? i_a_reg  : i_b_reg;
        sel_data = grant_a ? i_a_data : i_b_data;
    end

    assign o_a_ready = grant_a;
    assign o_b_ready = grant_b;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_b       <= 1'b1;
            src_b        <= 1'b0;
            o_RegWrite   <= 1'b0;
            o_Write_reg  <= 5'd0;
            o_Write_data <= 32'd0;
        end else begin
            // Index 0 still completes the handshake but never writes.
            o_RegWrite <= xfer && (sel_reg != 5'd0);
            src_b      <= grant_b;
            if (xfer) begin
                last_b       <= grant_b;
                o_Write_reg  <= sel_reg;
                o_Write_data <= sel_data;
            end
        end
    end

    // Clear lands on the same edge the register file captures the B data,
    // so busy drops exactly when the value becomes readable. Set wins.
    always_comb begin
        busy_clr = '0;
        busy_set = '0;
        if (o_RegWrite && src_b) begin
            busy_clr = 32'd1 << o_Write_reg;
        end
        if (i_issue_valid) begin
            busy_set = 32'd1 << i_issue_reg;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_busy <= '0;
        end else begin
            o_busy <= ((o_busy & ~busy_clr) | busy_set) & ~32'd1;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid, b_valid, issue_valid;
    logic [4:0]  a_reg, b_reg, issue_reg;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [31:0] busy;

    always #5 clk = ~clk;

    rf_wb_arbiter dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_a_valid     (a_valid),
        .i_a_reg       (a_reg),
        .i_a_data      (a_data),
        .o_a_ready     (a_ready),
        .i_b_valid     (b_valid),
        .i_b_reg       (b_reg),
        .i_b_data      (b_data),
        .o_b_ready     (b_ready),
        .i_issue_valid (issue_valid),
        .i_issue_reg   (issue_reg),
        .o_RegWrite    (reg_write),
        .o_Write_reg   (write_reg),
        .o_Write_data  (write_data),
        .o_busy        (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic bv, input logic [4:0] br, input logic [31:0] bd,
                         input logic iv, input logic [4:0] ir);
        a_valid = av; a_reg = ar; a_data = ad;
        b_valid = bv; b_reg = br; b_data = bd;
        issue_valid = iv; issue_reg = ir;
    endtask

    typedef struct {
        logic        av;  logic [4:0] ar; logic [31:0] ad;
        logic        bv;  logic [4:0] br; logic [31:0] bd;
        logic        iv;  logic [4:0] ir;
        logic        ea;  logic eb;
        logic        ewe; logic [4:0] ereg; logic [31:0] edata; logic [31:0] ebusy;
    } vec_t;

    function automatic vec_t mk(logic av, logic [4:0] ar, logic [31:0] ad,
                                logic bv, logic [4:0] br, logic [31:0] bd,
                                logic iv, logic [4:0] ir, logic ea, logic eb,
                                logic ewe, logic [4:0] ereg, logic [31:0] edata,
                                logic [31:0] ebusy);
        vec_t v;
        v.av = av; v.ar = ar; v.ad = ad; v.bv = bv; v.br = br; v.bd = bd;
        v.iv = iv; v.ir = ir; v.ea = ea; v.eb = eb;
        v.ewe = ewe; v.ereg = ereg; v.edata = edata; v.ebusy = ebusy;
        return v;
    endfunction

    vec_t tbl[15];

    // Reference model: who won last, the pending output write, and a set of
    // registers awaiting a B write.
    int          m_last;      // 0 = A, 1 = B
    bit          m_we;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    bit          m_from_b;
    bit          m_pending[32];

    task automatic model_reset();
        m_last = 1; m_we = 0; m_reg = 0; m_data = 0; m_from_b = 0;
        foreach (m_pending[r]) m_pending[r] = 0;
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] b = '0;
        for (int r = 0; r < 32; r++) b[r] = m_pending[r];
        return b;
    endfunction

    // Winner: 0 none, 1 A, 2 B.
    function automatic int model_winner();
        if (a_valid && b_valid) return (m_last == 1) ? 1 : 2;
        if (a_valid) return 1;
        if (b_valid) return 2;
        return 0;
    endfunction

    task automatic model_edge();
        int w = model_winner();
        if (m_we && m_from_b) m_pending[m_reg] = 0;
        if (issue_valid && issue_reg != 0) m_pending[issue_reg] = 1;
        m_from_b = (w == 2);
        if (w == 0) begin
            m_we = 0;
        end else begin
            m_last = w - 1;
            m_reg  = (w == 1) ? a_reg : b_reg;
            m_data = (w == 1) ? a_data : b_data;
            m_we   = (m_reg != 0);
        end
    endtask

    initial begin
        int w;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        //            A              B                   issue    rdyA rdyB  we reg data          busy
        tbl[0]  = mk(1, 1, 32'h11,  1, 2, 32'h22,       0, 0,    1, 0,  1, 1, 32'h11,       32'h0);
        tbl[1]  = mk(1, 1, 32'h11,  1, 2, 32'h22,       0, 0,    0, 1,  1, 2, 32'h22,       32'h0);
        tbl[2]  = mk(1, 1, 32'h11,  1, 2, 32'h22,       0, 0,    1, 0,  1, 1, 32'h11,       32'h0);
        tbl[3]  = mk(1, 1, 32'h11,  1, 2, 32'h22,       0, 0,    0, 1,  1, 2, 32'h22,       32'h0);
        tbl[4]  = mk(1, 5, 32'h12345678, 0, 0, 0,       0, 0,    1, 0,  1, 5, 32'h12345678, 32'h0);
        tbl[5]  = mk(0, 0, 0,       0, 0, 0,            0, 0,    0, 0,  0, 5, 32'h12345678, 32'h0);
        tbl[6]  = mk(0, 0, 0,       0, 0, 0,            1, 7,    0, 0,  0, 5, 32'h12345678, 32'h80);
        tbl[7]  = mk(0, 0, 0,       1, 7, 32'hDEADBEEF, 0, 0,    0, 1,  1, 7, 32'hDEADBEEF, 32'h80);
        tbl[8]  = mk(0, 0, 0,       0, 0, 0,            0, 0,    0, 0,  0, 7, 32'hDEADBEEF, 32'h0);
        tbl[9]  = mk(0, 0, 0,       0, 0, 0,            1, 9,    0, 0,  0, 7, 32'hDEADBEEF, 32'h200);
        tbl[10] = mk(0, 0, 0,       1, 9, 32'h99,       0, 0,    0, 1,  1, 9, 32'h99,       32'h200);
        tbl[11] = mk(0, 0, 0,       0, 0, 0,            1, 9,    0, 0,  0, 9, 32'h99,       32'h200);
        tbl[12] = mk(0, 0, 0,       0, 0, 0,            0, 0,    0, 0,  0, 9, 32'h99,       32'h200);
        tbl[13] = mk(1, 0, 32'hFFFFFFFF, 0, 0, 0,       0, 0,    1, 0,  0, 0, 32'hFFFFFFFF, 32'h200);
        tbl[14] = mk(0, 0, 0,       0, 0, 0,            1, 0,    0, 0,  0, 0, 32'hFFFFFFFF, 32'h200);

        repeat (2) @(negedge clk);
        chk("reset_we",   {31'd0, reg_write}, 32'd0);
        chk("reset_reg",  {27'd0, write_reg}, 32'd0);
        chk("reset_data", write_data, 32'd0);
        chk("reset_busy", busy, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(tbl[i].av, tbl[i].ar, tbl[i].ad, tbl[i].bv, tbl[i].br, tbl[i].bd,
                  tbl[i].iv, tbl[i].ir);
            #2;
            chk($sformatf("v%0d_a_ready", i), {31'd0, a_ready}, {31'd0, tbl[i].ea});
            chk($sformatf("v%0d_b_ready", i), {31'd0, b_ready}, {31'd0, tbl[i].eb});
            @(posedge clk); #1;
            chk($sformatf("v%0d_we", i),   {31'd0, reg_write}, {31'd0, tbl[i].ewe});
            chk($sformatf("v%0d_reg", i),  {27'd0, write_reg}, {27'd0, tbl[i].ereg});
            chk($sformatf("v%0d_data", i), write_data, tbl[i].edata);
            chk($sformatf("v%0d_busy", i), busy, tbl[i].ebusy);
        end

        // Mid-operation asynchronous reset with a B write in flight.
        @(negedge clk);
        drive(0, 0, 0, 1, 3, 32'h33, 1, 4);
        @(posedge clk); #1;
        chk("pre_rst_we",   {31'd0, reg_write}, 32'd1);
        chk("pre_rst_busy", busy, 32'h210);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_we",     {31'd0, reg_write}, 32'd0);
        chk("rst_reg",    {27'd0, write_reg}, 32'd0);
        chk("rst_data",   write_data, 32'd0);
        chk("rst_busy",   busy, 32'd0);
        chk("rst_rdy",    {30'd0, a_ready, b_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 6, 32'h66, 1, 8, 32'h88, 0, 0);
        #2;
        chk("post_rst_tie", {30'd0, a_ready, b_ready}, 32'b10);
        @(posedge clk); #1;
        chk("post_rst_reg", {27'd0, write_reg}, 32'd6);

        // Randomized phase against the model, from a fresh reset.
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            drive($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)));
            #2;
            w = model_winner();
            chk("rnd_a_ready", {31'd0, a_ready}, {31'd0, w == 1});
            chk("rnd_b_ready", {31'd0, b_ready}, {31'd0, w == 2});
            @(posedge clk);
            model_edge();
            #1;
            chk("rnd_we",   {31'd0, reg_write}, {31'd0, m_we});
            chk("rnd_reg",  {27'd0, write_reg}, {27'd0, m_reg});
            chk("rnd_data", write_data, m_data);
            chk("rnd_busy", busy, model_busy());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and pending-write scoreboard for the 32x32 register file. It shares the file's single write port between two producers: A, the single-cycle ALU/load path, and B, a long-latency unit such as a multiplier/divider. Grants are round-robin and the winning write is registered onto the RegWrite / Write_reg / Write_data port. A per-register busy mask lets the decode/stall logic hold instructions that read a register B has not yet written.

## Interface
- No parameters. Fixed: 32 registers, 5-bit index, 32-bit data.
- i_clk  in  1  clock; all state on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_a_valid  in  1  requester A has a write pending
- i_a_reg  in  5  A destination index
- i_a_data  in  32  A write data
- o_a_ready  out  1  A granted this cycle; transfer when i_a_valid & o_a_ready
- i_b_valid  in  1  requester B has a write pending
- i_b_reg  in  5  B destination index
- i_b_data  in  32  B write data
- o_b_ready  out  1  B granted this cycle
- i_issue_valid  in  1  a B-type operation is issued this cycle
- i_issue_reg  in  5  destination of the issued operation
- o_RegWrite  out  1  register-file write enable (registered)
- o_Write_reg  out  5  register-file write index (registered)
- o_Write_data  out  32  register-file write data (registered)
- o_busy  out  32  bit r = 1: register r awaits a B write

## Operation
- Arbitration (combinational from valids and the `last` pointer):
  - One valid requester: that requester is granted.
  - Both valid: the requester not granted most recently is granted.
  - Neither valid: no grant; both readies 0.
  - A ready is never asserted without its valid.
- On a transfer, `last` is updated to the granted requester. Reset value of `last` is B, so A wins the first tie.
- Output register, loaded on every edge:
  - On a transfer: o_Write_reg and o_Write_data take the granted request; o_RegWrite = 1 unless the index is 0. A write to index 0 completes its handshake but produces o_RegWrite = 0.
  - No transfer: o_RegWrite = 0; o_Write_reg and o_Write_data hold.
- An internal flag `src_b` is registered with the output and records that the current output write came from B.
- Scoreboard:
  - Set: on i_issue_valid with i_issue_reg != 0, busy[i_issue_reg] is set.
  - Clear: on an edge where o_RegWrite & src_b, busy[o_Write_reg] is cleared. This is the same edge at which the register file captures the data, so busy drops exactly when the data is readable.
  - Set and clear of the same register on the same edge: set wins.
  - busy[0] is always 0.
  - An A write never clears busy.
  - Issue to an already-busy register: busy stays 1 (no counting).
- Reset (asynchronous, any time, including mid-transfer): o_RegWrite = 0, o_Write_reg = 0, o_Write_data = 0, src_b = 0, o_busy = 0, `last` = B. Readies are combinational: 0 while no valid is asserted. Any in-flight output write is dropped.

## Timing
- A handshake at edge N drives o_RegWrite, o_Write_reg and o_Write_data during cycle N+1. The register file writes at edge N+1.
- Latency from request to register-file update: 2 edges when granted immediately.
- Throughput: one write per cycle. Under continuous dual requests, grants alternate A, B, A, B…
- Maximum wait for a continuously valid requester: 1 cycle.
- A B write accepted at edge N clears busy at edge N+1, so o_busy shows the bit low from cycle N+2 onward.
- An issue at edge N shows the bit high from cycle N+1 onward.

## Test plan
- Reset, then A only: a_valid=1, reg=5, data=0x1234_5678 -> o_a_ready=1 that cycle; next cycle o_RegWrite=1, o_Write_reg=5, o_Write_data=0x12345678; the following cycle o_RegWrite=0.
- Contention: A and B both valid for 4 cycles (A reg 1, B reg 2) -> grants A, B, A, B. o_Write_reg sequence 1, 2, 1, 2 with o_RegWrite=1 throughout.
- Scoreboard round-trip: issue reg 7 -> busy[7]=1 next cycle. B writes reg 7 with 0xDEADBEEF -> busy[7] falls the cycle after o_RegWrite is seen high with o_Write_reg=7.
- Collision: busy[9]=1, B write to reg 9 on the output, and i_issue_reg=9 on the same edge -> busy[9] remains 1.
- Register 0: A writes reg 0 with 0xFFFF_FFFF -> handshake completes and o_RegWrite stays 0. Issue reg 0 -> busy[0] stays 0.
- Mid-operation reset: B transfer accepted, then i_rst_n pulsed low asynchronously before the next edge -> o_RegWrite=0, o_busy=0 immediately. After release, a tie is granted to A.
